seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU for the execute stage. It keeps the existing single-cycle opcodes (add, sub, and, or) and adds xor, shifts, set-less-than, iterative multiply and iterative unsigned divide/remainder. Operands enter through a valid/ready handshake and results leave through one. The pipeline control stalls on `ready_o` and `valid_o` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, 32: operand and result width; power of two, at least 8.
- `SHW`, $clog2(WIDTH): local parameter, not overridable; number of shift-amount bits.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset (already decided).
- `valid_i`  in  1  operands and opcode are presented.
- `ready_o`  out  1  block can accept; high only in IDLE.
- `ALUCtrl_i`  in  4  opcode.
- `data1_i`  in  WIDTH  operand A.
- `data2_i`  in  WIDTH  operand B.
- `valid_o`  out  1  result is valid; high only in DONE.
- `ready_i`  in  1  consumer takes the result.
- `data_o`  out  WIDTH  result register.
- `zero_o`  out  1  high when `data_o` is 0; registered together with `data_o`.

## Operation
Opcodes:
- 0000 and; 0001 or; 0010 add; 0011 xor; 0110 sub.
- 0100 sll, 0101 srl, 0111 sra: shift amount is `data2_i[SHW-1:0]`.
- 1000 slt (signed), 1001 sltu: result is 0 or 1, zero-extended.
- 1010 mul: low WIDTH bits of the product.
- 1100 divu, 1101 remu.
- Any other code: result 0, single-cycle latency.

Arithmetic:
- All add, sub and mul results wrap modulo 2^WIDTH; there is no overflow flag.

Mul/div engines:
- mul: shift-add, one multiplier bit per cycle, WIDTH iterations.
- divu/remu: restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero skips iteration: divu returns all ones and remu returns `data1_i`, both with single-cycle latency.
- Operands are captured at acceptance, so inputs may change afterwards.

State machine:
- IDLE: `ready_o`=1. On `valid_i`:
  - single-cycle op → DONE, with result and `zero_o` registered.
  - mul → MUL; div/rem with nonzero divisor → DIV. Iteration counter set to 0.
- MUL / DIV: one step per cycle; counter increments. When counter = WIDTH-1 the step completes the result → DONE.
- DONE: `valid_o`=1; `data_o` and `zero_o` are held stable.
  - `ready_i`=1 → IDLE.
  - `ready_i`=0 → stay in DONE indefinitely.
- No input is accepted in MUL, DIV or DONE (`ready_o`=0), so a new op cannot overlap result hand-off.

Reset:
- Asserted at any time, including mid-iteration: state goes to IDLE, counter to 0, `data_o`=0, `zero_o`=1, `valid_o`=0, `ready_o`=1.
- An in-flight operation is discarded; no partial result is ever presented.

## Timing
- Acceptance edge: the rising edge where `valid_i` && `ready_o`.
- Single-cycle ops (including divide by zero and undefined codes): `valid_o` high in the cycle after the acceptance edge, so latency 1.
- mul/divu/remu: `valid_o` high WIDTH+1 cycles after the acceptance edge (33 for WIDTH=32). Latency does not depend on operand values.
- Back-to-back throughput for single-cycle ops: one op per 2 cycles (accept, DONE, IDLE) when `ready_i` is held high.
- `ready_o` falls in the cycle after acceptance and rises in the cycle after the DONE hand-off edge.
- `valid_o` and `ready_o` are decoded from state only; there is no combinational path from any input to any output.

## Test plan
- Reset release, `valid_i`=0 → `ready_o`=1, `valid_o`=0, `data_o`=0, `zero_o`=1.
- add 0xFFFFFFFF + 1, `ready_i`=1 → one cycle later `valid_o`=1, `data_o`=0, `zero_o`=1; next cycle `ready_o`=1.
- sra 0x80000000 by 4, with `data2_i`=0x24 (bits above SHW ignored) → 0xF8000000; slt −1 < 1 → 1; sltu 0xFFFFFFFF < 1 → 0.
- mul 0x00012345 × 0x00010000, `ready_i`=0 for 5 extra cycles:
  - `valid_o` rises exactly 33 cycles after acceptance.
  - `data_o`=0x23450000 held until `ready_i`=1.
  - `ready_o`=0 throughout, and a `valid_i` pulse meanwhile is ignored.
- divu 100/7 → 14, remu 100/7 → 2, each at 33-cycle latency; divu 5/0 → 0xFFFFFFFF and remu 5/0 → 5, each at 1-cycle latency.
- Start mul, assert `rst_i`=0 at iteration 10 → outputs are at reset values immediately; after release, add 2+3 → 5 at latency 1 with no stale mul result.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// slave is the ALU side; master is the pipeline side.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport slave (
    input  valid_i,
    input  ALUCtrl_i,
    input  data1_i,
    input  data2_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output zero_o
  );

  modport master (
    output valid_i,
    output ALUCtrl_i,
    output data1_i,
    output data2_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  zero_o
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops,
// shift-add multiply and restoring unsigned divide/remainder.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic    clk_i,
  input  logic    rst_i,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic             is_rem;
  logic [WIDTH-1:0] result;
  logic             zero;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res;
  logic             is_mul;
  logic             is_div;
  logic             last;

  assign a      = bus.data1_i;
  assign b      = bus.data2_i;
  assign sh     = b[SHW-1:0];
  assign is_mul = bus.ALUCtrl_i == 4'b1010;
  assign is_div = (bus.ALUCtrl_i[3:1] == 3'b110)
               && (b != '0);
  assign last   = cnt == SHW'(WIDTH - 1);

  always_comb begin
    res = '0;
    case (bus.ALUCtrl_i)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0011: res = a ^ b;
      4'b0110: res = a - b;
      4'b0100: res = a << sh;
      4'b0101: res = a >> sh;
      4'b0111: res = $unsigned($signed(a) >>> sh);
      4'b1000: res = {{(WIDTH-1){1'b0}},
                      $signed(a) < $signed(b)};
      4'b1001: res = {{(WIDTH-1){1'b0}}, a < b};
      // only reached here with a zero divisor
      4'b1100: res = '1;
      4'b1101: res = a;
      default: res = '0;
    endcase
  end

  logic [WIDTH-1:0] acc_nx;
  assign acc_nx = acc + (opb[0] ? opa : '0);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             fit;

  // restoring step: remainder stays below divisor, so bit WIDTH is 0
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign fit    = rem_sh >= {1'b0, opb};
  assign rem_nx = fit ? rem_sh - {1'b0, opb} : rem_sh;
  assign quo_nx = {quo[WIDTH-2:0], fit};

  logic [WIDTH-1:0] div_out;
  assign div_out = is_rem ? rem_nx[WIDTH-1:0] : quo_nx;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      is_rem <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            opa    <= a;
            opb    <= b;
            acc    <= '0;
            quo    <= a;
            rem    <= '0;
            is_rem <= bus.ALUCtrl_i[0];
            cnt    <= '0;
            if (is_mul) begin
              state <= MUL;
            end else if (is_div) begin
              state <= DIV;
            end else begin
              result <= res;
              zero   <= res == '0;
              state  <= DONE;
            end
          end
        end
        MUL: begin
          acc <= acc_nx;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= acc_nx;
            zero   <= acc_nx == '0;
            state  <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= div_out;
            zero   <= div_out == '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.ready_i) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o = state == IDLE;
  assign bus.valid_o = state == DONE;
  assign bus.data_o  = result;
  assign bus.zero_o  = zero;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: scoreboard of expected results
// and latencies, checked with immediate assertions.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] e,
                        input int lat,
                        input int hold);
    exp_t x;
    int cyc;
    logic busy_ok;
    logic [W-1:0] held;
    @(negedge clk);
    chk("ready_before", bus.ready_o, 1);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    bus.ready_i   = (hold == 0);
    sb.push_back('{e, lat});
    @(posedge clk);
    #1;
    bus.valid_i   = 1'b0;
    bus.data1_i   = $urandom;
    bus.data2_i   = $urandom;
    bus.ALUCtrl_i = 4'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.ready_o) busy_ok = 1'b0;
    end while (!bus.valid_o && cyc < 100);
    x = sb.pop_front();
    chk("busy_ready_low", busy_ok, 1);
    chk("latency", cyc, x.lat);
    chk("data", bus.data_o, x.data);
    chk("zero", bus.zero_o, x.data == '0);
    held = bus.data_o;
    for (int k = 0; k < hold; k++) begin
      bus.valid_i   = (k == 2);
      bus.ALUCtrl_i = 4'b0010;
      bus.data1_i   = 1;
      bus.data2_i   = 1;
      @(negedge clk);
      chk("hold_valid", bus.valid_o, 1);
      chk("hold_ready", bus.ready_o, 0);
      chk("hold_data", bus.data_o, held);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("handoff_valid", bus.valid_o, 0);
    chk("handoff_ready", bus.ready_o, 1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.ALUCtrl_i = '0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_zero", bus.zero_o, 1);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    run_op(4'b0111, 32'h8000_0000, 32'h24,
           32'hF800_0000, 1, 0);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
    run_op(4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00,
           32'h00F0_1200, 1, 0);
    run_op(4'b0001, 32'hF000_0001, 32'h0000_0F10,
           32'hF000_0F11, 1, 0);
    run_op(4'b0011, 32'hAAAA_5555, 32'hFFFF_0000,
           32'h5555_5555, 1, 0);
    run_op(4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 0);
    run_op(4'b0100, 32'h0000_0003, 32'h21,
           32'h0000_0006, 1, 0);
    run_op(4'b0101, 32'h8000_0000, 32'h1F,
           32'h0000_0001, 1, 0);
    run_op(4'b1111, 32'h1234, 32'h5678, 32'h0, 1, 0);

    run_op(4'b1010, 32'h0001_2345, 32'h0001_0000,
           32'h2345_0000, 33, 5);
    run_op(4'b1100, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op(4'b1101, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op(4'b1100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op(4'b1101, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op(4'b1101, 32'd21, 32'd7, 32'd0, 33, 0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h00FF_FFFF);
      run_op(4'b1010, ra, rb, ra * rb, 33, 0);
      run_op(4'b1100, ra, rb, ra / rb, 33, 0);
      run_op(4'b1101, ra, rb, ra % rb, 33, 0);
    end

    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 4'b1010;
    bus.data1_i   = 32'd7;
    bus.data2_i   = 32'd9;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", bus.ready_o, 1);
    chk("midrst_valid", bus.valid_o, 0);
    chk("midrst_data", bus.data_o, 0);
    chk("midrst_zero", bus.zero_o, 1);
    @(negedge clk);
    rst = 1'b1;
    run_op(4'b0010, 32'd2, 32'd3, 32'd5, 1, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
